// File: rtl/axi_arbiter_n.sv
// N-master to 1-slave AXI3 arbiter with independent read/write paths.
// Each path runs one burst at a time; the downstream ID carries the granted master index.
package axi_arbiter_pkg;
  typedef struct packed {
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  wid;
    logic        wlast;
    logic        wvalid;
    logic        rready;
    logic        bready;
  } axi_req_t;

  typedef struct packed {
    logic        arready;
    logic        awready;
    logic        wready;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
  } axi_resp_t;
endpackage

module axi_arbiter_n
  import axi_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  axi_req_t  m_req  [NUM_MASTERS],
  output axi_resp_t m_resp [NUM_MASTERS],
  output axi_req_t  s_req,
  input  axi_resp_t s_resp
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;

  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;
  logic [3:0] r_gnt_q, r_gnt_d, r_ptr_q, r_ptr_d;
  logic [3:0] w_gnt_q, w_gnt_d, w_ptr_q, w_ptr_d;
  logic [NUM_MASTERS-1:0] ar_req, aw_req;
  logic [4:0] r_pick, w_pick;
  logic unused_ids;

  // Returns {found, index}; search starts at ptr for round-robin, at 0 otherwise.
  function automatic logic [4:0] pick(input logic [NUM_MASTERS-1:0] req, input logic [3:0] ptr);
    logic [4:0] res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      j = (ROUND_ROBIN != 0) ? (32'(ptr) + k) % NUM_MASTERS : k;
      for (int unsigned i = 0; i < NUM_MASTERS; i++)
        if (!res[4] && i == j && req[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

  function automatic logic [3:0] next_ptr(input logic [3:0] idx);
    return (32'(idx) == NUM_MASTERS - 1) ? '0 : idx + 4'd1;
  endfunction

  always_comb begin
    ar_req     = '0;
    aw_req     = '0;
    unused_ids = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      ar_req[i]  = m_req[i].arvalid;
      aw_req[i]  = m_req[i].awvalid;
      unused_ids = unused_ids ^ (^{m_req[i].arid, m_req[i].awid, m_req[i].wid});
    end
    r_pick = pick(ar_req, r_ptr_q);
    w_pick = pick(aw_req, w_ptr_q);
  end

  // Handshake terms use the already state-gated downstream signals.
  always_comb begin
    r_state_d = r_state_q;
    r_gnt_d   = r_gnt_q;
    r_ptr_d   = r_ptr_q;
    w_state_d = w_state_q;
    w_gnt_d   = w_gnt_q;
    w_ptr_d   = w_ptr_q;
    case (r_state_q)
      R_IDLE: if (r_pick[4]) begin
        r_gnt_d   = r_pick[3:0];
        r_ptr_d   = next_ptr(r_pick[3:0]);
        r_state_d = R_ADDR;
      end
      R_ADDR: if (s_req.arvalid && s_resp.arready) r_state_d = R_DATA;
      R_DATA: if (s_resp.rvalid && s_req.rready && s_resp.rlast) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    case (w_state_q)
      W_IDLE: if (w_pick[4]) begin
        w_gnt_d   = w_pick[3:0];
        w_ptr_d   = next_ptr(w_pick[3:0]);
        w_state_d = W_ADDR;
      end
      W_ADDR: if (s_req.awvalid && s_resp.awready) w_state_d = W_DATA;
      W_DATA: if (s_req.wvalid && s_resp.wready && s_req.wlast) w_state_d = W_RESP;
      W_RESP: if (s_resp.bvalid && s_req.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_req = '0;
    if (r_state_q == R_ADDR) s_req.arid = r_gnt_q;
    if (w_state_q == W_ADDR) s_req.awid = w_gnt_q;
    if (w_state_q == W_DATA) s_req.wid  = w_gnt_q;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      m_resp[i] = '0;
      if (4'(i) == r_gnt_q) begin
        if (r_state_q == R_ADDR) begin
          s_req.araddr      = m_req[i].araddr;
          s_req.arlen       = m_req[i].arlen;
          s_req.arsize      = m_req[i].arsize;
          s_req.arburst     = m_req[i].arburst;
          s_req.arvalid     = m_req[i].arvalid;
          m_resp[i].arready = s_resp.arready;
        end
        if (r_state_q == R_DATA) begin
          s_req.rready     = m_req[i].rready;
          m_resp[i].rdata  = s_resp.rdata;
          m_resp[i].rid    = s_resp.rid;
          m_resp[i].rresp  = s_resp.rresp;
          m_resp[i].rlast  = s_resp.rlast;
          m_resp[i].rvalid = s_resp.rvalid;
        end
      end
      if (4'(i) == w_gnt_q) begin
        if (w_state_q == W_ADDR) begin
          s_req.awaddr      = m_req[i].awaddr;
          s_req.awlen       = m_req[i].awlen;
          s_req.awsize      = m_req[i].awsize;
          s_req.awburst     = m_req[i].awburst;
          s_req.awvalid     = m_req[i].awvalid;
          m_resp[i].awready = s_resp.awready;
        end
        if (w_state_q == W_DATA) begin
          s_req.wdata      = m_req[i].wdata;
          s_req.wstrb      = m_req[i].wstrb;
          s_req.wlast      = m_req[i].wlast;
          s_req.wvalid     = m_req[i].wvalid;
          m_resp[i].wready = s_resp.wready;
        end
        if (w_state_q == W_RESP) begin
          s_req.bready     = m_req[i].bready;
          m_resp[i].bid    = s_resp.bid;
          m_resp[i].bresp  = s_resp.bresp;
          m_resp[i].bvalid = s_resp.bvalid;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      r_gnt_q   <= '0;
      w_gnt_q   <= '0;
      r_ptr_q   <= '0;
      w_ptr_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      r_gnt_q   <= r_gnt_d;
      w_gnt_q   <= w_gnt_d;
      r_ptr_q   <= r_ptr_d;
      w_ptr_q   <= w_ptr_d;
    end
  end

endmodule
